// File: rtl/interrupt_system_if.sv
// Bundles SPR access, interrupt request/acknowledge and vector hand-off between the
// pipeline, devices and TLBs (master) and the interrupt controller (slave).
interface interrupt_system_if #(
   parameter int EXCEP_W = 4
);
   logic [9:0]         addr0, addr1, addr2;
   logic [0:31]        wd0, wd1, wd2;
   logic               wr0, wr1, wr2;
   logic [0:31]        rd0, rd1, rd2;
   logic [0:31]        MSR;
   logic [3:0]         entry_RW;
   logic [1:0]         entry_X;
   logic               isLoad, isStore, isFetch;
   logic               ITLB_req, DTLB_req, DEV0_req, DEV1_req, progErr_req, SC_req;
   logic [2:0]         progErrCode;
   logic               DSI_req, ISI_req;
   logic               DSI_ack, ISI_ack, ITLB_ack, DTLB_ack;
   logic               DEV0_ack, DEV1_ack, progErr_ack, SC_ack;
   logic               ack;
   logic [EXCEP_W-1:0] excepCode;
   logic [0:31]        intrEntryAddr;

   modport master (
      output addr0, addr1, addr2, wd0, wd1, wd2, wr0, wr1, wr2,
      output MSR, entry_RW, entry_X, isLoad, isStore, isFetch,
      output ITLB_req, DTLB_req, DEV0_req, DEV1_req, progErr_req, SC_req, progErrCode,
      input  rd0, rd1, rd2, DSI_req, ISI_req,
      input  DSI_ack, ISI_ack, ITLB_ack, DTLB_ack, DEV0_ack, DEV1_ack, progErr_ack, SC_ack,
      input  ack, excepCode, intrEntryAddr
   );

   modport slave (
      input  addr0, addr1, addr2, wd0, wd1, wd2, wr0, wr1, wr2,
      input  MSR, entry_RW, entry_X, isLoad, isStore, isFetch,
      input  ITLB_req, DTLB_req, DEV0_req, DEV1_req, progErr_req, SC_req, progErrCode,
      output rd0, rd1, rd2, DSI_req, ISI_req,
      output DSI_ack, ISI_ack, ITLB_ack, DTLB_ack, DEV0_ack, DEV1_ack, progErr_ack, SC_ack,
      output ack, excepCode, intrEntryAddr
   );
endinterface

// File: rtl/interrupt_system.sv
// Book-E style interrupt controller: interrupt SPRs, DSI/ISI permission fault detection,
// fixed-priority arbitration and exception code / vector hand-off to the control unit.
module interrupt_system #(
   parameter int EXCEP_W = 4
) (
   input logic               clk,
   input logic               rst,
   interrupt_system_if.slave bus
);
   localparam int SRC_N    = 8;
   localparam int SRC_PROG = 2;
   localparam int SRC_DSI  = 5;

   typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

   state_t             state_q, state_d;
   logic [2:0]         winner_q, winner_d;
   logic [EXCEP_W-1:0] excep_q, excep_d;
   logic [0:31]        entry_q, entry_d;
   logic               dsi_q, dsi_d, isi_q, isi_d, dsi_st_q, dsi_st_d;
   logic [0:31]        ivpr_q, ivpr_d, esr_q, esr_d;
   logic [0:31]        ivor_q [16];
   logic [0:31]        ivor_d [16];

   logic               pr, ee, dsi_det, isi_det;
   logic [0:SRC_N-1]   req_vec, ack_vec;
   logic [2:0]         win_idx;
   logic [3:0]         win_ivor;
   logic [9:0]         addr_a [3];
   logic [0:31]        wd_a [3];
   logic [0:2]         wr_a;
   logic [0:31]        rd_a [3];

   // Source index follows priority order: ITLB, ISI, progErr, SC, DTLB, DSI, DEV0, DEV1.
   function automatic logic [3:0] src_ivor(input logic [2:0] idx);
      case (idx)
         3'd0:    src_ivor = 4'd14;
         3'd1:    src_ivor = 4'd3;
         3'd2:    src_ivor = 4'd6;
         3'd3:    src_ivor = 4'd8;
         3'd4:    src_ivor = 4'd13;
         3'd5:    src_ivor = 4'd2;
         default: src_ivor = 4'd4;
      endcase
   endfunction

   assign addr_a[0] = bus.addr0;
   assign addr_a[1] = bus.addr1;
   assign addr_a[2] = bus.addr2;
   assign wd_a[0]   = bus.wd0;
   assign wd_a[1]   = bus.wd1;
   assign wd_a[2]   = bus.wd2;
   assign wr_a      = {bus.wr0, bus.wr1, bus.wr2};

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd_a[p] = '0;
         if (addr_a[p] == 10'd63)               rd_a[p] = ivpr_q;
         else if (addr_a[p] == 10'd62)          rd_a[p] = esr_q;
         else if (addr_a[p][9:4] == 6'b011001)  rd_a[p] = ivor_q[addr_a[p][3:0]];
      end
   end

   always_comb begin
      pr      = bus.MSR[17];
      ee      = bus.MSR[16];
      dsi_det = (bus.isLoad  && !(pr ? bus.entry_RW[3] : bus.entry_RW[1])) ||
                (bus.isStore && !(pr ? bus.entry_RW[2] : bus.entry_RW[0]));
      isi_det = bus.isFetch && !(pr ? bus.entry_X[1] : bus.entry_X[0]);
      req_vec = {bus.ITLB_req, isi_q, bus.progErr_req, bus.SC_req, bus.DTLB_req, dsi_q,
                 bus.DEV0_req & ee, bus.DEV1_req & ee};
      win_idx = '0;
      for (int i = SRC_N - 1; i >= 0; i--) begin
         if (req_vec[i]) win_idx = 3'(i);
      end
      win_ivor = src_ivor(win_idx);
      ack_vec  = '0;
      if (state_q == ACK) ack_vec[winner_q] = 1'b1;
   end

   // A new fault detection takes precedence over the clearing ack of the previous one.
   always_comb begin
      dsi_d    = dsi_det ? 1'b1 : (ack_vec[SRC_DSI] ? 1'b0 : dsi_q);
      isi_d    = isi_det ? 1'b1 : (ack_vec[1] ? 1'b0 : isi_q);
      dsi_st_d = dsi_det ? bus.isStore : dsi_st_q;
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      excep_d  = excep_q;
      entry_d  = entry_q;
      ivpr_d   = ivpr_q;
      esr_d    = esr_q;
      ivor_d   = ivor_q;
      for (int p = 0; p < 3; p++) begin
         if (wr_a[p]) begin
            if (addr_a[p] == 10'd63)               ivpr_d = wd_a[p];
            else if (addr_a[p] == 10'd62)          esr_d  = wd_a[p];
            else if (addr_a[p][9:4] == 6'b011001)  ivor_d[addr_a[p][3:0]] = wd_a[p];
         end
      end
      // Interrupt-driven ESR updates are applied last so they override SPR writes.
      case (state_q)
         IDLE: begin
            if (|req_vec) begin
               state_d  = ACK;
               winner_d = win_idx;
               excep_d  = EXCEP_W'(win_ivor);
               entry_d  = {ivpr_q[0:15], ivor_q[win_ivor][16:27], 4'b0000};
               if (win_idx == 3'(SRC_PROG)) begin
                  esr_d = {4'b0000, bus.progErrCode[0], bus.progErrCode[1],
                           bus.progErrCode[2], 25'b0};
               end else if (win_idx == 3'(SRC_DSI)) begin
                  esr_d    = '0;
                  esr_d[8] = dsi_st_q;
               end
            end
         end
         ACK:     state_d = WAIT;
         WAIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         winner_q <= '0;
         excep_q  <= '0;
         entry_q  <= '0;
         dsi_q    <= 1'b0;
         isi_q    <= 1'b0;
         dsi_st_q <= 1'b0;
         ivpr_q   <= '0;
         esr_q    <= '0;
         ivor_q   <= '{default: '0};
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         excep_q  <= excep_d;
         entry_q  <= entry_d;
         dsi_q    <= dsi_d;
         isi_q    <= isi_d;
         dsi_st_q <= dsi_st_d;
         ivpr_q   <= ivpr_d;
         esr_q    <= esr_d;
         ivor_q   <= ivor_d;
      end
   end

   assign bus.rd0           = rd_a[0];
   assign bus.rd1           = rd_a[1];
   assign bus.rd2           = rd_a[2];
   assign bus.DSI_req       = dsi_q;
   assign bus.ISI_req       = isi_q;
   assign bus.ack           = (state_q == ACK);
   assign bus.ITLB_ack      = ack_vec[0];
   assign bus.ISI_ack       = ack_vec[1];
   assign bus.progErr_ack   = ack_vec[2];
   assign bus.SC_ack        = ack_vec[3];
   assign bus.DTLB_ack      = ack_vec[4];
   assign bus.DSI_ack       = ack_vec[5];
   assign bus.DEV0_ack      = ack_vec[6];
   assign bus.DEV1_ack      = ack_vec[7];
   assign bus.excepCode     = excep_q;
   assign bus.intrEntryAddr = entry_q;
endmodule

// File: tb/tb_interrupt_system.sv
// Directed bench for interrupt_system: expected accepts are queued when requests are
// raised and checked by a monitor whenever the controller asserts ack.
module tb_interrupt_system;
   logic clk;
   logic rst;

   interrupt_system_if #(.EXCEP_W(4)) bus ();

   interrupt_system #(.EXCEP_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  code;
      logic [31:0] addr;
      logic [7:0]  acks;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [0:31] ivpr_m;
   logic [0:31] esr_m;
   logic [0:31] ivor_m [16];
   int          cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] vec_of(input int n);
      logic [0:31] v;
      v = ivor_m[n];
      return {ivpr_m[0:15], v[16:27], 4'b0000};
   endfunction

   task automatic expect_ack(input int code, input logic [7:0] mask);
      exp_q.push_back('{code[3:0], vec_of(code), mask});
   endtask

   task automatic spr_wr(input logic [9:0] a, input logic [31:0] d);
      bus.addr0 = a;
      bus.wd0   = d;
      bus.wr0   = 1'b1;
      @(negedge clk);
      bus.wr0 = 1'b0;
      if (a == 10'd63) ivpr_m = d;
      else if (a == 10'd62) esr_m = d;
      else if (a[9:4] == 6'b011001) ivor_m[a[3:0]] = d;
   endtask

   task automatic await_ack(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus.ack !== 1'b1 && cycles < budget);
      check_output("ack_seen", {31'b0, bus.ack}, 32'd1);
   endtask

   task automatic idle_gap();
      repeat (2) @(negedge clk);
   endtask

   task automatic check_spr(input string tag, input logic [9:0] a, input logic [31:0] exp);
      bus.addr0 = a;
      #1;
      check_output(tag, bus.rd0, exp);
   endtask

   // Scoreboard monitor: every accept must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.ack === 1'b1) begin
            tests++;
            assert (exp_q.size() > 0) else begin
               fails++;
               $error("[TB] FAIL unexpected_ack observed ack=1 code=%0d expected no ack", bus.excepCode);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_output("excepCode", {28'b0, bus.excepCode}, {28'b0, e.code});
               check_output("intrEntryAddr", bus.intrEntryAddr, e.addr);
               check_output("source_acks",
                            {24'b0, bus.ITLB_ack, bus.ISI_ack, bus.progErr_ack, bus.SC_ack,
                             bus.DTLB_ack, bus.DSI_ack, bus.DEV0_ack, bus.DEV1_ack},
                            {24'b0, e.acks});
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
      bus.wd0 = '0; bus.wd1 = '0; bus.wd2 = '0;
      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.wr2 = 1'b0;
      bus.MSR = '0; bus.entry_RW = 4'hF; bus.entry_X = 2'b11;
      bus.isLoad = 1'b0; bus.isStore = 1'b0; bus.isFetch = 1'b0;
      bus.ITLB_req = 1'b0; bus.DTLB_req = 1'b0; bus.DEV0_req = 1'b0; bus.DEV1_req = 1'b0;
      bus.progErr_req = 1'b0; bus.SC_req = 1'b0; bus.progErrCode = 3'b000;
      ivpr_m = '0;
      esr_m  = '0;
      for (int i = 0; i < 16; i++) ivor_m[i] = '0;

      repeat (2) @(negedge clk);
      check_output("rst_ack", {31'b0, bus.ack}, 32'd0);
      check_output("rst_excepCode", {28'b0, bus.excepCode}, 32'd0);
      check_output("rst_intrEntryAddr", bus.intrEntryAddr, 32'd0);
      check_output("rst_dsi_isi", {30'b0, bus.DSI_req, bus.ISI_req}, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Three-port write, no same-cycle bypass, then readback.
      bus.addr0 = 10'd402; bus.wd0 = 32'd2;  bus.wr0 = 1'b1;
      bus.addr1 = 10'd403; bus.wd1 = 32'd3;  bus.wr1 = 1'b1;
      bus.addr2 = 10'd413; bus.wd2 = 32'd13; bus.wr2 = 1'b1;
      #1;
      check_output("no_bypass", bus.rd0, 32'd0);
      @(negedge clk);
      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.wr2 = 1'b0;
      ivor_m[2] = 32'd2; ivor_m[3] = 32'd3; ivor_m[13] = 32'd13;
      #1;
      check_output("rd0_ivor2", bus.rd0, 32'd2);
      check_output("rd1_ivor3", bus.rd1, 32'd3);
      check_output("rd2_ivor13", bus.rd2, 32'd13);
      check_spr("rd_unmapped", 10'd100, 32'd0);

      // Same-address write priority.
      bus.addr0 = 10'd405; bus.wd0 = 32'hAAAA; bus.wr0 = 1'b1;
      bus.addr1 = 10'd405; bus.wd1 = 32'h1111; bus.wr1 = 1'b1;
      bus.addr2 = 10'd405; bus.wd2 = 32'h5555; bus.wr2 = 1'b1;
      @(negedge clk);
      bus.wr0 = 1'b0; bus.wr1 = 1'b0; bus.wr2 = 1'b0;
      ivor_m[5] = 32'h5555;
      check_spr("wr_priority", 10'd405, 32'h5555);

      spr_wr(10'd63,  32'h1234_0000);
      spr_wr(10'd404, 32'h0000_0040);
      spr_wr(10'd414, 32'h0000_01E0);
      spr_wr(10'd406, 32'h0000_0700);
      spr_wr(10'd408, 32'h0000_0800);
      check_spr("rd_ivpr", 10'd63, 32'h1234_0000);

      // DEV0 accepted with EE=1.
      bus.MSR = 32'h0000_C000;
      bus.DEV0_req = 1'b1;
      expect_ack(4, 8'b0000_0010);
      await_ack(5, cyc);
      bus.DEV0_req = 1'b0;
      check_output("dev0_latency", cyc, 32'd1);
      check_output("dev0_vector", bus.intrEntryAddr, 32'h1234_0040);
      idle_gap();

      // DEV0 masked with EE=0.
      bus.MSR = 32'h0;
      bus.DEV0_req = 1'b1;
      repeat (4) @(negedge clk);
      check_output("dev0_masked", {31'b0, bus.DEV0_ack | bus.ack}, 32'd0);
      bus.DEV0_req = 1'b0;

      // ITLB beats DTLB; DTLB follows three cycles later.
      bus.ITLB_req = 1'b1; bus.DTLB_req = 1'b1;
      expect_ack(14, 8'b1000_0000);
      expect_ack(13, 8'b0000_1000);
      await_ack(5, cyc);
      bus.ITLB_req = 1'b0;
      check_output("itlb_latency", cyc, 32'd1);
      await_ack(8, cyc);
      bus.DTLB_req = 1'b0;
      check_output("b2b_spacing", cyc, 32'd3);
      idle_gap();

      // DSI from user load without UR.
      bus.MSR = 32'h0000_4000;
      bus.entry_RW = 4'b0111;
      bus.isLoad = 1'b1;
      @(negedge clk);
      bus.isLoad = 1'b0;
      check_output("dsi_req_set", {31'b0, bus.DSI_req}, 32'd1);
      expect_ack(2, 8'b0000_0100);
      await_ack(5, cyc);
      check_output("dsi_latency", cyc, 32'd1);
      @(negedge clk);
      check_output("dsi_req_clear", {31'b0, bus.DSI_req}, 32'd0);
      @(negedge clk);
      esr_m = 32'h0;
      check_spr("esr_dsi_load", 10'd62, esr_m);

      // DSI from user store without UW sets ESR[ST].
      bus.entry_RW = 4'b1011;
      bus.isStore = 1'b1;
      @(negedge clk);
      bus.isStore = 1'b0;
      expect_ack(2, 8'b0000_0100);
      await_ack(5, cyc);
      idle_gap();
      esr_m = 32'h0080_0000;
      check_spr("esr_dsi_store", 10'd62, esr_m);

      // ISI from user fetch without UX.
      bus.entry_X = 2'b01;
      bus.isFetch = 1'b1;
      @(negedge clk);
      bus.isFetch = 1'b0;
      check_output("isi_req_set", {31'b0, bus.ISI_req}, 32'd1);
      expect_ack(3, 8'b0100_0000);
      await_ack(5, cyc);
      idle_gap();

      // Program trap; same-cycle ESR SPR write must lose.
      bus.progErrCode = 3'b100;
      bus.progErr_req = 1'b1;
      bus.addr0 = 10'd62; bus.wd0 = 32'hFFFF_FFFF; bus.wr0 = 1'b1;
      expect_ack(6, 8'b0010_0000);
      await_ack(5, cyc);
      bus.wr0 = 1'b0;
      bus.progErr_req = 1'b0;
      idle_gap();
      esr_m = 32'h0200_0000;
      check_spr("esr_progerr", 10'd62, esr_m);

      // SC beats DEV0; ESR untouched.
      bus.MSR = 32'h0000_C000;
      bus.SC_req = 1'b1; bus.DEV0_req = 1'b1;
      expect_ack(8, 8'b0001_0000);
      expect_ack(4, 8'b0000_0010);
      await_ack(5, cyc);
      bus.SC_req = 1'b0;
      await_ack(8, cyc);
      bus.DEV0_req = 1'b0;
      idle_gap();
      check_spr("esr_sc_unchanged", 10'd62, esr_m);

      // Reset during ACK, then held DEV1 request re-accepted.
      bus.DEV1_req = 1'b1;
      expect_ack(4, 8'b0000_0001);
      await_ack(5, cyc);
      #2;
      rst = 1'b0;
      #1;
      check_output("rst_mid_ack", {31'b0, bus.ack | bus.DEV1_ack}, 32'd0);
      check_output("rst_mid_code", {28'b0, bus.excepCode}, 32'd0);
      check_output("rst_mid_addr", bus.intrEntryAddr, 32'd0);
      ivpr_m = '0;
      esr_m  = '0;
      for (int i = 0; i < 16; i++) ivor_m[i] = '0;
      check_spr("rst_esr", 10'd62, esr_m);
      @(negedge clk);
      rst = 1'b1;
      expect_ack(4, 8'b0000_0001);
      await_ack(5, cyc);
      bus.DEV1_req = 1'b0;
      check_output("rearb_latency", cyc, 32'd1);
      repeat (3) @(negedge clk);

      check_output("scoreboard_drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
